// File: rtl/regfile_writeback_arbiter_if.sv
// Writeback bus bundle: ALU and load-unit result requests in, register-file
// write port and scoreboard out. The slave modport is the arbiter's view.
interface regfile_writeback_arbiter_if #(
    parameter int CNT_W = 3
);
    logic              alu_valid;
    logic              alu_ready;
    logic              alu_wide;
    logic [4:0]        alu_dest;
    logic [15:0]       alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic              mem_wide;
    logic [4:0]        mem_dest;
    logic [15:0]       mem_data;
    logic [1:0]        wr_en;
    logic [9:0]        wr_addr;
    logic [15:0]       wr_data;
    logic [31:0]       reg_busy;
    logic [CNT_W-1:0]  mem_fifo_count;

    modport slave (
        input  alu_valid, alu_wide, alu_dest, alu_data,
        input  mem_valid, mem_wide, mem_dest, mem_data,
        output alu_ready, mem_ready, wr_en, wr_addr, wr_data, reg_busy, mem_fifo_count
    );

    modport master (
        output alu_valid, alu_wide, alu_dest, alu_data,
        output mem_valid, mem_wide, mem_dest, mem_data,
        input  alu_ready, mem_ready, wr_en, wr_addr, wr_data, reg_busy, mem_fifo_count
    );
endinterface

// File: rtl/regfile_writeback_arbiter.sv
// Writeback arbiter: buffers load results, round-robins them against ALU
// results and drives the 2-lane register-file write port. WB_MERGE_EN enables
// pairing two narrow writes (ALU lane0, FIFO head lane1) into one cycle.
module regfile_writeback_arbiter #(
    parameter int MEM_FIFO_DEPTH = 4,
    parameter int CNT_W          = 3
) (
    input  logic                      clock,
    input  logic                      nreset,
    regfile_writeback_arbiter_if.slave bus
);
    localparam int AW = $clog2(MEM_FIFO_DEPTH);

    logic [MEM_FIFO_DEPTH-1:0]        fwide_q;
    logic [MEM_FIFO_DEPTH-1:0][4:0]   fdest_q;
    logic [MEM_FIFO_DEPTH-1:0][15:0]  fdata_q;
    logic [AW-1:0]                    rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic                             fifo_pref_q, fifo_pref_d;
    logic [1:0]                       wr_en_q, wr_en_d;
    logic [9:0]                       wr_addr_q, wr_addr_d;
    logic [15:0]                      wr_data_q, wr_data_d;

    logic        has_head, fifo_full, push, merge, conflict, fifo_wins;
    logic        gnt_alu, gnt_fifo;
    logic        head_wide;
    logic [4:0]  head_dest;
    logic [15:0] head_data;

    // Formats one source into {wr_en, wr_addr, wr_data}; wide writes pair dest with dest+1 mod 32.
    function automatic logic [27:0] fmt_write(input logic wide, input logic [4:0] dest,
                                              input logic [15:0] data);
        if (wide) return {2'b11, dest + 5'd1, dest, data};
        return {2'b01, 5'd0, dest, 8'h00, data[7:0]};
    endfunction

    assign head_wide = fwide_q[rd_ptr_q];
    assign head_dest = fdest_q[rd_ptr_q];
    assign head_data = fdata_q[rd_ptr_q];
    assign has_head  = (cnt_q != '0);
    assign fifo_full = (cnt_q == CNT_W'(MEM_FIFO_DEPTH));
    assign push      = bus.mem_valid & ~fifo_full;

`ifdef WB_MERGE_EN
    assign merge = bus.alu_valid & has_head & ~bus.alu_wide & ~head_wide &
                   (bus.alu_dest != head_dest);
`else
    assign merge = 1'b0;
`endif

    // A full FIFO overrides the round-robin so loads cannot back up indefinitely.
    assign conflict  = bus.alu_valid & has_head & ~merge;
    assign fifo_wins = fifo_full | fifo_pref_q;
    assign gnt_alu   = bus.alu_valid & (~has_head | merge | ~fifo_wins);
    assign gnt_fifo  = has_head & (~bus.alu_valid | merge | fifo_wins);
    assign fifo_pref_d = conflict ? gnt_alu : fifo_pref_q;
    assign cnt_d     = cnt_q + CNT_W'(push) - CNT_W'(gnt_fifo);

    assign bus.alu_ready      = gnt_alu;
    assign bus.mem_ready      = ~fifo_full;
    assign bus.mem_fifo_count = cnt_q;
    assign bus.wr_en          = wr_en_q;
    assign bus.wr_addr        = wr_addr_q;
    assign bus.wr_data        = wr_data_q;

    always_comb begin
        {wr_en_d, wr_addr_d, wr_data_d} = '0;
        if (merge) begin
            wr_en_d   = 2'b11;
            wr_addr_d = {head_dest, bus.alu_dest};
            wr_data_d = {head_data[7:0], bus.alu_data[7:0]};
        end else if (gnt_alu) begin
            {wr_en_d, wr_addr_d, wr_data_d} = fmt_write(bus.alu_wide, bus.alu_dest, bus.alu_data);
        end else if (gnt_fifo) begin
            {wr_en_d, wr_addr_d, wr_data_d} = fmt_write(head_wide, head_dest, head_data);
        end
    end

    always_comb begin
        bus.reg_busy = '0;
        if (wr_en_q[0]) bus.reg_busy[wr_addr_q[4:0]] = 1'b1;
        if (wr_en_q[1]) bus.reg_busy[wr_addr_q[9:5]] = 1'b1;
        for (int i = 0; i < MEM_FIFO_DEPTH; i++) begin
            if (CNT_W'(i) < cnt_q) begin
                bus.reg_busy[fdest_q[rd_ptr_q + AW'(i)]] = 1'b1;
                if (fwide_q[rd_ptr_q + AW'(i)])
                    bus.reg_busy[fdest_q[rd_ptr_q + AW'(i)] + 5'd1] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            fifo_pref_q <= 1'b1;
            wr_en_q     <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            if (push)     wr_ptr_q <= wr_ptr_q + AW'(1);
            if (gnt_fifo) rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q       <= cnt_d;
            fifo_pref_q <= fifo_pref_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            fwide_q[wr_ptr_q] <= bus.mem_wide;
            fdest_q[wr_ptr_q] <= bus.mem_dest;
            fdata_q[wr_ptr_q] <= bus.mem_data;
        end
    end
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for regfile_writeback_arbiter: queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_regfile_writeback_arbiter;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic clock = 1'b0;
    logic nreset = 1'b0;
    always #5 clock = ~clock;

    regfile_writeback_arbiter_if #(.CNT_W(CNT_W)) ifc ();

    regfile_writeback_arbiter #(.MEM_FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .nreset(nreset),
        .bus   (ifc.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        wide;
        logic [4:0]  dest;
        logic [15:0] data;
    } ent_t;

    ent_t        mq[$];
    bit          fifo_pref = 1'b1;
    logic [1:0]  e_en   = '0;
    logic [9:0]  e_addr = '0;
    logic [15:0] e_data = '0;

    function automatic void decide(output bit ga, output bit gf, output bit mg);
        bit ha = ifc.alu_valid;
        bit hf = (mq.size() > 0);
        ga = 0; gf = 0; mg = 0;
`ifdef WB_MERGE_EN
        if (ha && hf && !ifc.alu_wide && !mq[0].wide && ifc.alu_dest != mq[0].dest) mg = 1;
`endif
        if (mg) begin
            ga = 1; gf = 1;
        end else if (ha && hf) begin
            if (mq.size() == DEPTH || fifo_pref) gf = 1;
            else ga = 1;
        end else begin
            ga = ha; gf = hf;
        end
    endfunction

    function automatic void fmt(input bit w, input logic [4:0] d, input logic [15:0] x,
                                output logic [1:0] en, output logic [9:0] a, output logic [15:0] dd);
        if (w) begin
            en = 2'b11; a = {5'(d + 1), d}; dd = x;
        end else begin
            en = 2'b01; a = {5'd0, d}; dd = {8'h00, x[7:0]};
        end
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] b = '0;
        foreach (mq[i]) begin
            b[mq[i].dest] = 1'b1;
            if (mq[i].wide) b[5'(mq[i].dest + 1)] = 1'b1;
        end
        if (e_en[0]) b[e_addr[4:0]] = 1'b1;
        if (e_en[1]) b[e_addr[9:5]] = 1'b1;
        return b;
    endfunction

    initial forever begin
        @(posedge clock or negedge nreset);
        if (!nreset) begin
            mq.delete();
            fifo_pref = 1'b1;
            e_en = '0; e_addr = '0; e_data = '0;
        end else begin
            bit ga, gf, mg;
            int sz0;
            ent_t h;
            sz0 = mq.size();
            decide(ga, gf, mg);
            if (ifc.alu_valid && sz0 > 0 && !mg) fifo_pref = ga;
            e_en = '0; e_addr = '0; e_data = '0;
            if (mg) begin
                e_en = 2'b11;
                e_addr = {mq[0].dest, ifc.alu_dest};
                e_data = {mq[0].data[7:0], ifc.alu_data[7:0]};
            end else if (ga) fmt(ifc.alu_wide, ifc.alu_dest, ifc.alu_data, e_en, e_addr, e_data);
            else if (gf) fmt(mq[0].wide, mq[0].dest, mq[0].data, e_en, e_addr, e_data);
            if (gf) h = mq.pop_front();
            if (ifc.mem_valid && sz0 < DEPTH) mq.push_back({ifc.mem_wide, ifc.mem_dest, ifc.mem_data});
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        bit ga, gf, mg;
        @(negedge clock);
        decide(ga, gf, mg);
        check("m_alu_ready", 32'(ifc.alu_ready), 32'(ga));
        check("m_mem_ready", 32'(ifc.mem_ready), 32'(mq.size() < DEPTH));
        check("m_count",     32'(ifc.mem_fifo_count), 32'(mq.size()));
        check("m_wr_en",     32'(ifc.wr_en), 32'(e_en));
        check("m_wr_addr",   32'(ifc.wr_addr), 32'(e_addr));
        check("m_wr_data",   32'(ifc.wr_data), 32'(e_data));
        check("m_reg_busy",  ifc.reg_busy, model_busy());
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic idle_inputs();
        ifc.alu_valid = 0; ifc.alu_wide = 0; ifc.alu_dest = '0; ifc.alu_data = '0;
        ifc.mem_valid = 0; ifc.mem_wide = 0; ifc.mem_dest = '0; ifc.mem_data = '0;
    endtask

    task automatic set_alu(input bit w, input logic [4:0] d, input logic [15:0] x);
        ifc.alu_valid = 1; ifc.alu_wide = w; ifc.alu_dest = d; ifc.alu_data = x;
    endtask

    task automatic set_mem(input bit w, input logic [4:0] d, input logic [15:0] x);
        ifc.mem_valid = 1; ifc.mem_wide = w; ifc.mem_dest = d; ifc.mem_data = x;
    endtask

    task automatic do_reset();
        idle_inputs();
        nreset = 0;
        tick(); tick();
        nreset = 1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    bit exp_ar[8]  = '{1, 0, 1, 0, 1, 0, 1, 0};
    bit exp_mr[8]  = '{1, 1, 1, 1, 1, 1, 1, 0};
    int exp_cnt[8] = '{0, 1, 1, 2, 2, 3, 3, 4};

    initial begin
        idle_inputs();
        tick(); tick();
        check("rst_wr_en", 32'(ifc.wr_en), 0);
        check("rst_count", 32'(ifc.mem_fifo_count), 0);
        check("rst_busy", ifc.reg_busy, 0);
        nreset = 1;
        tick();

        // ALU narrow write
        set_alu(0, 5'd5, 16'h00A7);
        #1 check("alu_n_ready", 32'(ifc.alu_ready), 1);
        tick();
        idle_inputs();
        check("alu_n_en", 32'(ifc.wr_en), 32'h1);
        check("alu_n_addr", 32'(ifc.wr_addr), 32'h005);
        check("alu_n_data", 32'(ifc.wr_data), 32'h00A7);
        check("alu_n_busy5", 32'(ifc.reg_busy[5]), 1);

        // ALU wide write wrapping dest 31 -> 0
        set_alu(1, 5'd31, 16'hBEEF);
        tick();
        idle_inputs();
        check("alu_w_en", 32'(ifc.wr_en), 32'h3);
        check("alu_w_addr", 32'(ifc.wr_addr), 32'h01F);
        check("alu_w_data", 32'(ifc.wr_data), 32'hBEEF);
        check("alu_w_busy", ifc.reg_busy, 32'h8000_0001);
        tick();

        // Four loads retire in order, first write two cycles after first push
        for (int i = 1; i <= 4; i++) begin
            set_mem(0, 5'(i), 16'(8'h50 + i));
            tick();
            if (i == 1) check("mem_first_idle", 32'(ifc.wr_en), 0);
            else check("mem_order_addr", 32'(ifc.wr_addr), 32'(i - 1));
        end
        idle_inputs();
        tick();
        check("mem_last_addr", 32'(ifc.wr_addr), 32'h004);
        check("mem_last_data", 32'(ifc.wr_data), 32'h0054);
        tick();
        check("mem_drained_en", 32'(ifc.wr_en), 0);

        // Fill the FIFO against a competing wide ALU stream
        begin
            int n = 0;
            set_alu(1, 5'd20, 16'h1234);
            set_mem(0, 5'd10, 16'h0066);
            while (ifc.mem_fifo_count != 3'd4 && n < 20) begin
                tick();
                n++;
            end
            check("fill_count", 32'(ifc.mem_fifo_count), 4);
            #1;
            check("full_mem_ready", 32'(ifc.mem_ready), 0);
            check("full_alu_blocked", 32'(ifc.alu_ready), 0);
            idle_inputs();
            for (int k = 0; k < 6; k++) tick();
        end

        // Merge pair: ALU narrow dest 2 vs FIFO head narrow dest 9
        do_reset();
        set_mem(0, 5'd9, 16'h0022);
        tick();
        idle_inputs();
        set_alu(0, 5'd2, 16'h0011);
`ifdef WB_MERGE_EN
        #1 check("merge_alu_ready", 32'(ifc.alu_ready), 1);
        tick();
        idle_inputs();
        check("merge_en", 32'(ifc.wr_en), 32'h3);
        check("merge_addr", 32'(ifc.wr_addr), 32'h122);
        check("merge_data", 32'(ifc.wr_data), 32'h2211);
`else
        #1 check("nomerge_alu_ready", 32'(ifc.alu_ready), 0);
        tick();
        check("nomerge_en0", 32'(ifc.wr_en), 32'h1);
        check("nomerge_addr0", 32'(ifc.wr_addr), 32'h009);
        check("nomerge_data0", 32'(ifc.wr_data), 32'h0022);
        tick();
        idle_inputs();
        check("nomerge_en1", 32'(ifc.wr_en), 32'h1);
        check("nomerge_addr1", 32'(ifc.wr_addr), 32'h002);
        check("nomerge_data1", 32'(ifc.wr_data), 32'h0011);
`endif
        tick(); tick();

        // Same destination from both sides: alternation, then full forces FIFO
        do_reset();
        for (int c = 0; c < 8; c++) begin
            set_alu(0, 5'd7, 16'(8'h30 + c));
            set_mem(0, 5'd7, 16'(8'h40 + c));
            #1;
            check("rr_alu_ready", 32'(ifc.alu_ready), 32'(exp_ar[c]));
            check("rr_mem_ready", 32'(ifc.mem_ready), 32'(exp_mr[c]));
            check("rr_count", 32'(ifc.mem_fifo_count), 32'(exp_cnt[c]));
            tick();
        end
        check("rr_final_count", 32'(ifc.mem_fifo_count), 3);
        check("rr_final_en", 32'(ifc.wr_en), 32'h1);
        check("rr_final_data", 32'(ifc.wr_data), 32'h0043);

        // Async reset mid-operation discards everything
        #1;
        nreset = 0;
        idle_inputs();
        #1;
        check("arst_en", 32'(ifc.wr_en), 0);
        check("arst_addr", 32'(ifc.wr_addr), 0);
        check("arst_count", 32'(ifc.mem_fifo_count), 0);
        check("arst_busy", ifc.reg_busy, 0);
        tick(); tick();
        nreset = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("post_rst_en", 32'(ifc.wr_en), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_writeback_arbiter.md
Name: regfile_writeback_arbiter

Overview:
Writeback stage that sits directly upstream of the byte-wide dual-port register file (32 x 8-bit, two byte write lanes).
- Accepts result requests from the ALU and from the memory-load unit.
- Buffers load results in a small FIFO and arbitrates between the two sources.
- Drives the register file's wr_en/wr_addr/data_in as registered outputs, merging two narrow writes into one cycle where legal.
- Exports a pending-write scoreboard to the issue stage.

Parameters:
MEM_FIFO_DEPTH, 4, load-result FIFO entries (power of 2, >=2)
CNT_W, 3, width of mem_fifo_count (log2(MEM_FIFO_DEPTH)+1)

Ports:
clock  in  1  system clock, all state on posedge
nreset  in  1  asynchronous active-low reset
alu_valid  in  1  ALU result offered
alu_ready  out  1  ALU result accepted this cycle (combinational)
alu_wide  in  1  1 = 16-bit register-pair write, 0 = 8-bit write
alu_dest  in  5  destination register (low byte register for wide)
alu_data  in  16  result; [7:0] only when narrow
mem_valid  in  1  load result offered
mem_ready  out  1  FIFO not full
mem_wide  in  1  as alu_wide
mem_dest  in  5  as alu_dest
mem_data  in  16  as alu_data
wr_en  out  2  to register file wr_en (bit0 lane0, bit1 lane1)
wr_addr  out  10  to register file wr_addr ([4:0] lane0, [9:5] lane1)
wr_data  out  16  to register file data_in ([7:0] lane0, [15:8] lane1)
reg_busy  out  32  bit n = write to register n pending
mem_fifo_count  out  CNT_W  FIFO occupancy

Behaviour:
- Reset (async, nreset=0):
  - wr_en=0, wr_addr=0, wr_data=0.
  - FIFO empty, count=0, reg_busy=0.
  - Round-robin pointer = FIFO-preferred.
  - Reset mid-operation discards all queued and in-flight writes; nothing reaches the register file after reset.
- MEM path:
  - Push when mem_valid & mem_ready; mem_ready = count < MEM_FIFO_DEPTH.
  - No same-cycle bypass; a pushed entry is eligible from the next cycle.
  - Simultaneous push and pop when full is not allowed, since mem_ready=0.
  - Push and pop in the same cycle when not full: count unchanged.
- ALU path:
  - Unbuffered. alu_ready is combinational from alu_valid/alu_wide/alu_dest and the FIFO head.
  - Upstream must not make alu_valid depend on alu_ready.
- Grant logic each cycle, candidates ALU (alu_valid) and FIFO head (count>0):
  - One candidate: it is granted.
  - Both candidates, merge legal (see Optional Feature): both granted.
  - Otherwise conflict: FIFO is granted if FIFO is full; else the side not granted in the previous conflict is granted.
  - The pointer updates only on conflict cycles.
- Output register (latched on posedge; value present the cycle after grant):
  - Narrow single write: wr_en=01, wr_addr[4:0]=dest, wr_data[7:0]=data[7:0]; unused fields 0.
  - Wide write: wr_en=11, wr_addr={(dest+1) mod 32, dest}, wr_data=data[15:0]. dest=31 wraps the high byte to register 0.
  - No grant: wr_en=00, wr_addr=0, wr_data=0.
- Latency:
  - ALU accept to wr_en asserted: 1 cycle.
  - MEM accept to wr_en asserted: minimum 2 cycles.
- reg_busy is combinational: OR of dest bits (plus dest+1 mod 32 for wide) over valid FIFO entries and the current output-register write.
- Ordering: FIFO entries retire in order. No ordering guarantee between ALU and MEM beyond grant order.

Optional Feature:
- Macro WB_MERGE_EN.
- Defined: merge is legal when ALU and FIFO head are both narrow and alu_dest != head dest. Both are granted in the same cycle:
  - ALU on lane0: wr_addr[4:0], wr_data[7:0].
  - FIFO head on lane1: wr_addr[9:5]=head dest, wr_data[15:8]=head data[7:0].
  - wr_en=11.
  - The round-robin pointer is not updated.
- Not defined: merge is never legal and at most one source is granted per cycle; wr_en is only ever 00, 01, or 11 (wide).

Test Plan:
- ALU narrow, dest=5, data=0x00A7, FIFO empty -> alu_ready=1; next cycle wr_en=01, wr_addr=0x005, wr_data=0x00A7, reg_busy[5]=1 in that cycle.
- ALU wide, dest=31, data=0xBEEF -> next cycle wr_en=11, wr_addr={5'd0,5'd31}=0x01F, wr_data=0xBEEF; reg_busy[31] and reg_busy[0] set.
- MEM pushes 4 narrow loads (dest 1..4) with no ALU traffic -> mem_ready=0 at count=4; writes retire in order dest 1,2,3,4 on consecutive cycles starting 2 cycles after the first push.
- WB_MERGE_EN on: ALU narrow dest=2 data=0x11, FIFO head narrow dest=9 data=0x22 -> wr_en=11, wr_addr=0x122, wr_data=0x2211. Macro off -> two separate single writes.
- Same dest=7 from both sources continuously, FIFO not full -> grants alternate FIFO, ALU, FIFO…; FIFO full forces FIFO grant.
- nreset pulsed low while FIFO count=3 and wr_en=01 -> wr_en=0 immediately (async), count=0, reg_busy=0, no further writes after release.
